result_bcast_arb: RTL and testbench

//  Transmit side of the reservation-station register-update bus. Collects results from

---
 rtl/rs_pkg.sv | 16 +
 rtl/bcast_fifo.sv | 69 ++++++
 rtl/result_bcast_arb.sv | 124 ++++++++++++
 tb/tb_result_bcast_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared widths and result record for the reservation-station register-update bus.
package rs_pkg;

  localparam int unsigned W_rx_a     = 5;
  localparam int unsigned W_rx_d     = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  // r0 is hardwired zero and never pending, so no RS cell matches it
  localparam logic [W_rx_a-1:0] NULL_ADDR = W_rx_a'(0);

  typedef struct packed {
    logic [W_rx_a-1:0] rd_a;
    logic [W_rx_d-1:0] rd_d;
  } result_t;

endpackage

// File: rtl/bcast_fifo.sv
// Per-pipe result FIFO: synchronous push/pop, async clear, sync flush.
module bcast_fifo
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          flush,
  input  logic          push,
  input  result_t       din,
  input  logic          pop,
  output result_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;
  result_t       mem_q [DEPTH];

  // Push is gated on pre-edge fullness, so a full FIFO never accepts even when popping
  always_comb begin
    push_ok  = push && !full && !flush;
    pop_ok   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;

endmodule

// File: rtl/result_bcast_arb.sv
// Register-update bus transmitter: round-robin between pipe0/pipe1 result FIFOs,
// one registered (addr, data) broadcast per cycle.
module result_bcast_arb
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              flush,
  input  logic              i_p0_v,
  input  logic [W_rx_a-1:0] i_p0_rd_a,
  input  logic [W_rx_d-1:0] i_p0_rd_d,
  output logic              o_p0_ready,
  input  logic              i_p1_v,
  input  logic [W_rx_a-1:0] i_p1_rd_a,
  input  logic [W_rx_d-1:0] i_p1_rd_d,
  output logic              o_p1_ready,
  output logic [W_rx_a-1:0] addr_reg_upt,
  output logic [W_rx_d-1:0] data_reg_upt,
  output logic              o_bcast_v,
  output logic              o_ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic RR_P0 = 1'b0;
  localparam logic RR_P1 = 1'b1;

  result_t           p0_din, p1_din, p0_head, p1_head;
  logic              p0_full, p1_full, p0_empty, p1_empty;
  logic [CW-1:0]     p0_count, p1_count;
  logic              p0_push, p1_push, p0_grant, p1_grant;
  logic              rr_q, rr_d;
  logic [W_rx_a-1:0] addr_q, addr_d;
  logic [W_rx_d-1:0] data_q, data_d;
  logic              bcast_v_q, bcast_v_d;
  logic              ovf_q, ovf_d;

  assign p0_din = '{rd_a: i_p0_rd_a, rd_d: i_p0_rd_d};
  assign p1_din = '{rd_a: i_p1_rd_a, rd_d: i_p1_rd_d};

  bcast_fifo #(.DEPTH(DEPTH)) u_p0_fifo (
    .clk     (clk),
    .clear_n (clear_n),
    .flush   (flush),
    .push    (p0_push),
    .din     (p0_din),
    .pop     (p0_grant),
    .dout    (p0_head),
    .full    (p0_full),
    .empty   (p0_empty),
    .count   (p0_count)
  );

  bcast_fifo #(.DEPTH(DEPTH)) u_p1_fifo (
    .clk     (clk),
    .clear_n (clear_n),
    .flush   (flush),
    .push    (p1_push),
    .din     (p1_din),
    .pop     (p1_grant),
    .dout    (p1_head),
    .full    (p1_full),
    .empty   (p1_empty),
    .count   (p1_count)
  );

  assign o_p0_ready = (p0_count != CW'(DEPTH));
  assign o_p1_ready = (p1_count != CW'(DEPTH));

  // Arbitration and next broadcast; the pointer only moves when both heads competed
  always_comb begin
    p0_push   = i_p0_v && o_p0_ready && (i_p0_rd_a != NULL_ADDR);
    p1_push   = i_p1_v && o_p1_ready && (i_p1_rd_a != NULL_ADDR);
    p0_grant  = 1'b0;
    p1_grant  = 1'b0;
    rr_d      = rr_q;
    addr_d    = NULL_ADDR;
    data_d    = data_q;
    bcast_v_d = 1'b0;
    ovf_d     = ovf_q || (i_p0_v && p0_full) || (i_p1_v && p1_full);
    if (!flush) begin
      if (!p0_empty && !p1_empty) begin
        p0_grant = (rr_q == RR_P0);
        p1_grant = (rr_q == RR_P1);
        rr_d     = ~rr_q;
      end else begin
        p0_grant = !p0_empty;
        p1_grant = !p1_empty;
      end
      if (p0_grant) begin
        addr_d    = p0_head.rd_a;
        data_d    = p0_head.rd_d;
        bcast_v_d = 1'b1;
      end else if (p1_grant) begin
        addr_d    = p1_head.rd_a;
        data_d    = p1_head.rd_d;
        bcast_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rr_q      <= RR_P0;
      addr_q    <= NULL_ADDR;
      data_q    <= W_rx_d'(0);
      bcast_v_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bcast_v_q <= bcast_v_d;
      ovf_q     <= ovf_d;
    end
  end

  assign addr_reg_upt = addr_q;
  assign data_reg_upt = data_q;
  assign o_bcast_v    = bcast_v_q;
  assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_result_bcast_arb.sv
// Bench for result_bcast_arb: queue-based reference model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_result_bcast_arb;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        flush = 1'b0;
  logic        i_p0_v = 1'b0, i_p1_v = 1'b0;
  logic [4:0]  i_p0_rd_a = '0, i_p1_rd_a = '0;
  logic [31:0] i_p0_rd_d = '0, i_p1_rd_d = '0;
  logic        o_p0_ready, o_p1_ready, o_bcast_v, o_ovf;
  logic [4:0]  addr_reg_upt;
  logic [31:0] data_reg_upt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  result_bcast_arb #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .flush        (flush),
    .i_p0_v       (i_p0_v),
    .i_p0_rd_a    (i_p0_rd_a),
    .i_p0_rd_d    (i_p0_rd_d),
    .o_p0_ready   (o_p0_ready),
    .i_p1_v       (i_p1_v),
    .i_p1_rd_a    (i_p1_rd_a),
    .i_p1_rd_d    (i_p1_rd_d),
    .o_p1_ready   (o_p1_ready),
    .addr_reg_upt (addr_reg_upt),
    .data_reg_upt (data_reg_upt),
    .o_bcast_v    (o_bcast_v),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues of {addr,data}, a round-robin preference bit
  logic [36:0] m_q0[$], m_q1[$];
  logic [36:0] m_e;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_v, m_ovf, m_f0, m_f1;
  int          m_rr, m_w;

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_q0.delete(); m_q1.delete();
      m_addr = 0; m_data = 0; m_v = 0; m_ovf = 0; m_rr = 0;
    end else begin
      m_f0 = (m_q0.size() == DEPTH);
      m_f1 = (m_q1.size() == DEPTH);
      if ((i_p0_v && m_f0) || (i_p1_v && m_f1)) m_ovf = 1;
      if (flush) begin
        m_q0.delete(); m_q1.delete();
        m_v = 0; m_addr = 0;
      end else begin
        m_w = -1;
        if (m_q0.size() != 0 && m_q1.size() != 0) begin
          m_w = m_rr; m_rr = 1 - m_rr;
        end else if (m_q0.size() != 0) m_w = 0;
        else if (m_q1.size() != 0) m_w = 1;
        m_v = 0; m_addr = 0;
        if (m_w == 0) m_e = m_q0.pop_front();
        if (m_w == 1) m_e = m_q1.pop_front();
        if (m_w >= 0) begin
          m_v = 1; m_addr = m_e[36:32]; m_data = m_e[31:0];
        end
        if (i_p0_v && !m_f0 && i_p0_rd_a != 0) m_q0.push_back({i_p0_rd_a, i_p0_rd_d});
        if (i_p1_v && !m_f1 && i_p1_rd_a != 0) m_q1.push_back({i_p1_rd_a, i_p1_rd_d});
      end
    end
  end

  logic [4:0] bc_log[$];

  // Every-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (clear_n && chk_en) begin
      chk("addr", 64'(addr_reg_upt), 64'(m_addr));
      chk("data", 64'(data_reg_upt), 64'(m_data));
      chk("bcast_v", 64'(o_bcast_v), 64'(m_v));
      chk("ovf", 64'(o_ovf), 64'(m_ovf));
      chk("p0_ready", 64'(o_p0_ready), 64'(m_q0.size() < DEPTH));
      chk("p1_ready", 64'(o_p1_ready), 64'(m_q1.size() < DEPTH));
      if (o_bcast_v) bc_log.push_back(addr_reg_upt);
    end
  end

  // Apply inputs for one edge, then return idle at the following negedge
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic fl);
    i_p0_v = v0; i_p0_rd_a = a0; i_p0_rd_d = d0;
    i_p1_v = v1; i_p1_rd_a = a1; i_p1_rd_d = d1;
    flush = fl;
    @(negedge clk);
    i_p0_v = 0; i_p1_v = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  bit   hit, ord_ok;
  int   last0, last1, cnt0;

  initial begin
    // Power-on reset
    #1;
    chk("rst_addr", 64'(addr_reg_upt), 64'h0);
    chk("rst_v", 64'(o_bcast_v), 64'h0);
    idle(2);
    clear_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rdy0", 64'(o_p0_ready), 64'h1);
    chk("rst_rdy1", 64'(o_p1_ready), 64'h1);
    chk("rst_data", 64'(data_reg_upt), 64'h0);

    // Single push: visible one cycle after the accepting edge, for one cycle only
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("single_E_v", 64'(o_bcast_v), 64'h0);
    idle(1);
    chk("single_addr", 64'(addr_reg_upt), 64'd5);
    chk("single_data", 64'(data_reg_upt), 64'hDEADBEEF);
    chk("single_v", 64'(o_bcast_v), 64'h1);
    idle(1);
    chk("single_idle_addr", 64'(addr_reg_upt), 64'h0);
    chk("single_idle_v", 64'(o_bcast_v), 64'h0);
    chk("single_hold_data", 64'(data_reg_upt), 64'hDEADBEEF);

    // Contention with pointer at p0
    drive(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0);
    idle(1);
    chk("cont_first", 64'(addr_reg_upt), 64'd3);
    idle(1);
    chk("cont_second", 64'(addr_reg_upt), 64'd7);
    chk("cont_second_data", 64'(data_reg_upt), 64'h77);
    idle(1);
    chk("cont_idle_v", 64'(o_bcast_v), 64'h0);

    // Null-address push is dropped
    bc_log.delete();
    drive(0, 0, 0, 1, 5'd0, 32'h1234, 0);
    chk("null_rdy1", 64'(o_p1_ready), 64'h1);
    idle(2);
    chk("null_v", 64'(o_bcast_v), 64'h0);
    chk("null_ovf", 64'(o_ovf), 64'h0);
    chk("null_nolog", 64'(bc_log.size()), 64'd0);

    // Saturation: both pipes push every cycle; fill-and-drop expected from edge 7 on
    bc_log.delete();
    for (int i = 0; i < 10; i++)
      drive(1, 5'(i + 1), 32'(i + 100), 1, 5'(i + 17), 32'(i + 200), 0);
    idle(12);
    chk("sat_ovf", 64'(o_ovf), 64'h1);
    chk("sat_count", 64'(bc_log.size()), 64'd16);
    ord_ok = 1; last0 = 0; last1 = 0; cnt0 = 0;
    foreach (bc_log[k]) begin
      if (bc_log[k] < 17) begin
        if (int'(bc_log[k]) <= last0) ord_ok = 0;
        last0 = int'(bc_log[k]); cnt0++;
      end else begin
        if (int'(bc_log[k]) <= last1) ord_ok = 0;
        last1 = int'(bc_log[k]);
      end
    end
    chk("sat_inorder", 64'(ord_ok), 64'h1);
    chk("sat_p0_count", 64'(cnt0), 64'd8);

    // Flush discards queued and same-cycle results
    bc_log.delete();
    drive(1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 0);
    drive(1, 5'd11, 32'hB, 0, 0, 0, 1);
    chk("flush_addr", 64'(addr_reg_upt), 64'h0);
    chk("flush_v", 64'(o_bcast_v), 64'h0);
    chk("flush_rdy0", 64'(o_p0_ready), 64'h1);
    chk("flush_rdy1", 64'(o_p1_ready), 64'h1);
    idle(3);
    hit = 0;
    foreach (bc_log[k]) if (bc_log[k] inside {5'd9, 5'd10, 5'd11}) hit = 1;
    chk("flush_nobcast", 64'(hit), 64'h0);
    chk("flush_ovf_kept", 64'(o_ovf), 64'h1);

    // Asynchronous reset in the middle of traffic
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0);
    drive(1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 0);
    chk("mid_pre_v", 64'(o_bcast_v), 64'h1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("mid_rst_addr", 64'(addr_reg_upt), 64'h0);
    chk("mid_rst_v", 64'(o_bcast_v), 64'h0);
    chk("mid_rst_ovf", 64'(o_ovf), 64'h0);
    idle(2);
    clear_n = 1'b1;
    @(negedge clk);
    chk("mid_rdy0", 64'(o_p0_ready), 64'h1);
    chk("mid_rdy1", 64'(o_p1_ready), 64'h1);
    idle(2);
    chk("mid_no_partial", 64'(o_bcast_v), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
